// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl -- pipeline hazard and sequencing controller for the 5-stage MIPS
// core. It sits beside ID and produces the PC / IF/ID write enables, the IF/ID
// and ID/EX flush controls, and the launch/busy handshake of the multi-cycle
// mult/div unit, whose busy window is timed by an internal latency counter.
//
// Parameters:
//   MULDIV_CYCLES  mult/div execution latency in cycles (>= 2)
//   CNT_W          busy-counter width, MULDIV_CYCLES <= 2**CNT_W
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-low reset
//   ID_Rs/ID_Rt    source register fields of the instruction in ID
//   ID_UsesRt      ID instruction reads rt as a source
//   ID_Jump        ID instruction is j/jal/jr/jalr
//   ID_MulDiv      ID instruction is mult/multu/div/divu
//   ID_ReadsHiLo   ID instruction is mfhi/mflo
//   EX_MemRead     EX instruction is a load
//   EX_Rt          load destination register in EX
//   EX_BranchTaken branch resolved taken in EX
//   PC_Write       PC load enable
//   IFID_Write     IF/ID load enable
//   IFID_Flush     clear IF/ID to a bubble
//   IDEX_Flush     clear ID/EX control fields
//   MulDiv_Start   one-cycle launch pulse to the mult/div unit
//   MulDiv_Busy    high while the mult/div unit is executing
//
// Optional feature (macro HAZ_STATS_EN):
//   Stall_Count    saturating count of stall cycles not overridden by a branch
//   Flush_Count    saturating count of cycles with IFID_Flush out of reset
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_W         = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] ID_Rs,
    input  logic [4:0] ID_Rt,
    input  logic       ID_UsesRt,
    input  logic       ID_Jump,
    input  logic       ID_MulDiv,
    input  logic       ID_ReadsHiLo,
    input  logic       EX_MemRead,
    input  logic [4:0] EX_Rt,
    input  logic       EX_BranchTaken,
    output logic       PC_Write,
    output logic       IFID_Write,
    output logic       IFID_Flush,
    output logic       IDEX_Flush,
    output logic       MulDiv_Start,
    output logic       MulDiv_Busy
`ifdef HAZ_STATS_EN
    ,
    output logic [31:0] Stall_Count,
    output logic [31:0] Flush_Count
`endif
);

    typedef enum logic {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic load_use;
    logic hilo_stall;
    logic stall;

    // Hazard detection. $zero is never a real dependence.
    assign load_use   = EX_MemRead && (EX_Rt != 5'd0) &&
                        ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));
    assign hilo_stall = (state_q == MD_BUSY) && (ID_ReadsHiLo || ID_MulDiv);
    assign stall      = load_use || hilo_stall;

    // Output decode, all combinational so that stalls take effect in the
    // same cycle the hazard is seen.
    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // if/else chain can leave a value held, which would infer a latch.
        PC_Write     = 1'b1;
        IFID_Write   = 1'b1;
        IFID_Flush   = 1'b0;
        IDEX_Flush   = 1'b0;
        MulDiv_Start = (state_q == IDLE) && ID_MulDiv && !EX_BranchTaken && !load_use;
        MulDiv_Busy  = (state_q == MD_BUSY);

        if (!reset) begin
            PC_Write     = 1'b0;
            IFID_Write   = 1'b0;
            IFID_Flush   = 1'b1;
            IDEX_Flush   = 1'b1;
            MulDiv_Start = 1'b0;
            MulDiv_Busy  = 1'b0;
        end else if (EX_BranchTaken) begin
            // The ID instruction is wrong-path: squash it even if it would stall.
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
        end else if (stall) begin
            PC_Write   = 1'b0;
            IFID_Write = 1'b0;
            IDEX_Flush = 1'b1;
        end else if (ID_Jump) begin
            IFID_Flush = 1'b1;
        end
    end

    // Next-state logic for the mult/div busy window. The counter only loads on
    // a launch and only decrements while non-zero, so it can never wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (MulDiv_Start) begin
                    state_d = MD_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            MD_BUSY: begin
                // A taken branch does not abort the window: the op is committed.
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge value, independent of statement order.
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZ_STATS_EN
    logic [31:0] stall_count_q;
    logic [31:0] flush_count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            if (stall && !EX_BranchTaken && (stall_count_q != 32'hFFFF_FFFF)) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
            if (IFID_Flush && (flush_count_q != 32'hFFFF_FFFF)) begin
                flush_count_q <= flush_count_q + 32'd1;
            end
        end
    end

    assign Stall_Count = stall_count_q;
    assign Flush_Count = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl -- self-checking bench for hazard_ctrl with MULDIV_CYCLES=4.
// A table of single-cycle vectors covers the combinational hazard/priority
// decode; hand-written sequences cover the mult/div busy window, stalled
// mfhi/mult release, a branch inside the window and a reset inside the window.
// Output vector order: {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush,
//                       MulDiv_Start, MulDiv_Busy}.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] ID_Rs, ID_Rt, EX_Rt;
    logic       ID_UsesRt, ID_Jump, ID_MulDiv, ID_ReadsHiLo, EX_MemRead, EX_BranchTaken;
    logic       PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, MulDiv_Start, MulDiv_Busy;
`ifdef HAZ_STATS_EN
    logic [31:0] Stall_Count, Flush_Count;
`endif

    hazard_ctrl #(.MULDIV_CYCLES(4), .CNT_W(6)) dut (
        .clk            (clk),
        .reset          (reset),
        .ID_Rs          (ID_Rs),
        .ID_Rt          (ID_Rt),
        .ID_UsesRt      (ID_UsesRt),
        .ID_Jump        (ID_Jump),
        .ID_MulDiv      (ID_MulDiv),
        .ID_ReadsHiLo   (ID_ReadsHiLo),
        .EX_MemRead     (EX_MemRead),
        .EX_Rt          (EX_Rt),
        .EX_BranchTaken (EX_BranchTaken),
        .PC_Write       (PC_Write),
        .IFID_Write     (IFID_Write),
        .IFID_Flush     (IFID_Flush),
        .IDEX_Flush     (IDEX_Flush),
        .MulDiv_Start   (MulDiv_Start),
        .MulDiv_Busy    (MulDiv_Busy)
`ifdef HAZ_STATS_EN
        ,
        .Stall_Count    (Stall_Count),
        .Flush_Count    (Flush_Count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       jump;
        logic       muldiv;
        logic       hilo;
        logic       memread;
        logic [4:0] ex_rt;
        logic       br;
        logic [5:0] exp;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    logic [5:0] outs;
    assign outs = {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, MulDiv_Start, MulDiv_Busy};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [4:0] rs, input logic [4:0] rt,
                                input logic uses_rt, input logic jump, input logic muldiv,
                                input logic hilo, input logic memread, input logic [4:0] ex_rt,
                                input logic br, input logic [5:0] exp);
        vec_t v;
        v.name = name; v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.jump = jump;
        v.muldiv = muldiv; v.hilo = hilo; v.memread = memread; v.ex_rt = ex_rt;
        v.br = br; v.exp = exp;
        return v;
    endfunction

    // One cycle: drive at the falling edge, check 1 ns later, the rising edge
    // that follows commits the state update.
    task automatic step(input vec_t v, input logic rst_v);
        @(negedge clk);
        reset          = rst_v;
        ID_Rs          = v.rs;
        ID_Rt          = v.rt;
        ID_UsesRt      = v.uses_rt;
        ID_Jump        = v.jump;
        ID_MulDiv      = v.muldiv;
        ID_ReadsHiLo   = v.hilo;
        EX_MemRead     = v.memread;
        EX_Rt          = v.ex_rt;
        EX_BranchTaken = v.br;
        #1;
        check(v.name, {26'd0, outs}, {26'd0, v.exp});
    endtask

    vec_t tbl [12];

    initial begin
        reset = 1'b0;
        ID_Rs = '0; ID_Rt = '0; EX_Rt = '0;
        ID_UsesRt = 1'b0; ID_Jump = 1'b0; ID_MulDiv = 1'b0; ID_ReadsHiLo = 1'b0;
        EX_MemRead = 1'b0; EX_BranchTaken = 1'b0;

        //            name             rs  rt  urt jmp md  hl  mr  exrt br  expected
        tbl[0]  = mk("idle_nop",        0,  0, 0,  0,  0,  0,  0,  0,  0, 6'b110000);
        tbl[1]  = mk("load_use_rs",     8,  3, 0,  0,  0,  0,  1,  8,  0, 6'b000100);
        tbl[2]  = mk("load_rt0_nostall",0,  0, 1,  0,  0,  0,  1,  0,  0, 6'b110000);
        tbl[3]  = mk("rt_dep_unused",   1,  9, 0,  0,  0,  0,  1,  9,  0, 6'b110000);
        tbl[4]  = mk("rt_dep_used",     1,  9, 1,  0,  0,  0,  1,  9,  0, 6'b000100);
        tbl[5]  = mk("br_over_loaduse", 8,  3, 0,  0,  0,  0,  1,  8,  1, 6'b111100);
        tbl[6]  = mk("jump",            2,  3, 1,  1,  0,  0,  0,  0,  0, 6'b111000);
        tbl[7]  = mk("stall_over_jump", 8,  3, 0,  1,  0,  0,  1,  8,  0, 6'b000100);
        tbl[8]  = mk("md_blocked_lu",   8,  3, 0,  0,  1,  0,  1,  8,  0, 6'b000100);
        tbl[9]  = mk("md_blocked_br",   4,  5, 1,  0,  1,  0,  0,  0,  1, 6'b111100);
        tbl[10] = mk("load_no_match",   7,  6, 1,  0,  0,  0,  1,  8,  0, 6'b110000);
        tbl[11] = mk("mfhi_idle",       0,  0, 0,  0,  0,  1,  0,  0,  0, 6'b110000);

        // Reset values held for two cycles.
        step(mk("reset_a", 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b001100), 1'b0);
        step(mk("reset_lu", 8, 3, 0, 0, 1, 0, 1, 8, 1, 6'b001100), 1'b0);
`ifdef HAZ_STATS_EN
        check("stall_cnt_reset", Stall_Count, 32'd0);
        check("flush_cnt_reset", Flush_Count, 32'd0);
`endif

        for (int i = 0; i < 12; i++) begin
            step(tbl[i], 1'b1);
        end

        // Launch at T, mfhi stalled T+1..T+4, proceeds at T+5.
        step(mk("md_start",       0, 0, 0, 0, 1, 0, 0, 0, 0, 6'b110010), 1'b1);
        for (int i = 1; i <= 4; i++) begin
            step(mk("mfhi_stall",  0, 0, 0, 0, 0, 1, 0, 0, 0, 6'b000101), 1'b1);
        end
        step(mk("mfhi_release",   0, 0, 0, 0, 0, 1, 0, 0, 0, 6'b110000), 1'b1);

        // Launch, a second mult/div stalls the whole window, then relaunches.
        step(mk("md_start2",      0, 0, 0, 0, 1, 0, 0, 0, 0, 6'b110010), 1'b1);
        for (int i = 1; i <= 4; i++) begin
            step(mk("md_held",     0, 0, 0, 0, 1, 0, 0, 0, 0, 6'b000101), 1'b1);
        end
        step(mk("md_relaunch",    0, 0, 0, 0, 1, 0, 0, 0, 0, 6'b110010), 1'b1);

        // Relaunched window: branch at T+2 flushes but does not end busy early.
        step(mk("busy_t1",        0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b110001), 1'b1);
        step(mk("busy_branch",    0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b111101), 1'b1);
        step(mk("busy_t3",        0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b110001), 1'b1);
        step(mk("busy_t4",        0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b110001), 1'b1);
        step(mk("busy_done",      0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b110000), 1'b1);

        // Reset inside the busy window, then a fresh launch.
        step(mk("rst_md_start",   0, 0, 0, 0, 1, 0, 0, 0, 0, 6'b110010), 1'b1);
        step(mk("rst_busy_t1",    0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b110001), 1'b1);
        step(mk("rst_mid_busy",   0, 0, 0, 0, 1, 1, 0, 0, 0, 6'b001100), 1'b0);
        step(mk("rst_released",   0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b110000), 1'b1);
`ifdef HAZ_STATS_EN
        check("stall_cnt_after_rst", Stall_Count, 32'd0);
        check("flush_cnt_after_rst", Flush_Count, 32'd0);
`endif
        step(mk("relaunch_start", 0, 0, 0, 0, 1, 0, 0, 0, 0, 6'b110010), 1'b1);
        step(mk("relaunch_busy",  0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b110001), 1'b1);
        // mfhi stalls for the remainder: one stall cycle for the counter below.
        step(mk("relaunch_mfhi",  0, 0, 0, 0, 0, 1, 0, 0, 0, 6'b000101), 1'b1);
        step(mk("relaunch_jump",  0, 0, 0, 1, 0, 0, 0, 0, 0, 6'b111001), 1'b1);
        step(mk("relaunch_t4",    0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b110001), 1'b1);
`ifdef HAZ_STATS_EN
        check("stall_cnt_one", Stall_Count, 32'd1);
        check("flush_cnt_one", Flush_Count, 32'd1);
`endif
        step(mk("relaunch_done",  0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b110000), 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
